uart_tx_feeder: RTL

//  Byte queue and launch controller directly upstream of the UART transmitter.

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_tx_feeder.sv | 98 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the tx-side feeder and the rx-side queue.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } feeder_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_TXQ_DEPTH = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; rd_data shows the head entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guards live here so count can never pass DEPTH or drop below zero.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues MMIO bytes and launches them into the UART transmitter one at a time.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DEPTH     = UART_TXQ_DEPTH,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 clr_ovf,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow,
    output logic                 busy,
    output logic                 tx_start,
    output logic [DATA_BITS-1:0] tx_din,
    input  logic                 tx_done
);

    feeder_state_e        state;
    feeder_state_e        state_n;
    logic                 tx_start_n;
    logic [DATA_BITS-1:0] tx_din_n;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Handshake with tx: tx_start is a one-cycle launch that tx accepts
    // unconditionally; tx_din stays put until tx answers with a one-cycle
    // tx_done. GAP adds one cycle so tx is idle again before the next launch.
    always_comb begin
        state_n    = state;
        tx_start_n = 1'b0;
        tx_din_n   = tx_din;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    tx_din_n   = head;
                    tx_start_n = 1'b1;
                    pop        = 1'b1;
                    state_n    = WAIT;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    state_n = GAP;
                end
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_din   <= '0;
        end else begin
            state    <= state_n;
            tx_start <= tx_start_n;
            tx_din   <= tx_din_n;
        end
    end

    // A dropped push outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule
